// File: rtl/frame_seq_ctrl.sv
// frame_seq_ctrl: once-per-frame sequencer for the receive test path.
// Runs the RAM-write stage and then the MAC-read stage, each through a
// four-phase fs/fd handshake. It also provides an optional inter-stage gap,
// a per-phase timeout, abort, a free-running loop mode, a frame counter and
// a state export for debug. All status outputs decode from registered state.
module frame_seq_ctrl #(
  parameter int unsigned GAP_CYC = 2,     // idle cycles between write release and read start
  parameter int unsigned TIMEOUT = 4096,  // max cycles per handshake phase, 0 disables
  parameter int unsigned TO_W    = 16     // counter width, must hold TIMEOUT and GAP_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        loop_en,
  input  logic        abort,
  input  logic        err_clr,
  output logic        fs_wr,
  input  logic        fd_wr,
  output logic        fs_rd,
  input  logic        fd_rd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_cnt,
  output logic [7:0]  so
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWr    = 3'd1,
    StWrRel = 3'd2,
    StGap   = 3'd3,
    StRd    = 3'd4,
    StRdRel = 3'd5,
    StDone  = 3'd6,
    StErr   = 3'd7
  } state_e;

  // Last count value of a timed phase and of the gap; only meaningful when
  // the corresponding parameter is non-zero.
  localparam logic [TO_W-1:0] ToLast  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] GapLast = TO_W'(GAP_CYC - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [15:0]     frame_cnt_q;
  logic            timed;
  logic            to_hit;
  logic            frame_inc;

  // Handshake phases that are guarded by the timeout.
  always_comb begin
    timed = (state_q == StWr) || (state_q == StWrRel) ||
            (state_q == StRd) || (state_q == StRdRel);
    to_hit = (TIMEOUT != 0) && timed && (cnt_q == ToLast);
  end

  // Next state and error code; abort beats err_clr beats timeout beats handshake.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      if (state_q == StErr) begin
        err_code_d = 2'd0;
      end
    end else if (state_q == StErr) begin
      if (err_clr) begin
        state_d    = StIdle;
        err_code_d = 2'd0;
      end
    end else if (to_hit) begin
      // Timeout wins even if the awaited fd edge arrives in the same cycle.
      state_d    = StErr;
      err_code_d = ((state_q == StWr) || (state_q == StWrRel)) ? 2'd1 : 2'd2;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StWr;
          end
        end
        StWr: begin
          // fd_rd is not looked at here, so a spurious read done is ignored.
          if (fd_wr) begin
            state_d = StWrRel;
          end
        end
        StWrRel: begin
          if (!fd_wr) begin
            state_d = (GAP_CYC > 0) ? StGap : StRd;
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            state_d = StRd;
          end
        end
        StRd: begin
          if (fd_rd) begin
            state_d = StRdRel;
          end
        end
        StRdRel: begin
          if (!fd_rd) begin
            state_d = StDone;
          end
        end
        StDone: begin
          state_d = loop_en ? StWr : StIdle;
        end
        StErr: begin
          state_d = StErr;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Shared phase/gap counter: restarts on every state change.
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (timed || (state_q == StGap)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  // A frame counts only when DONE is left normally, not through abort.
  always_comb begin
    frame_inc = (state_q == StDone) && !abort;
  end

  // State, counter and error code registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_code_q <= err_code_d;
    end
  end

  // Completed-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= 16'd0;
    end else if (frame_inc) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    fs_wr     = (state_q == StWr);
    fs_rd     = (state_q == StRd);
    busy      = (state_q != StIdle) && (state_q != StErr);
    done      = (state_q == StDone);
    err       = (state_q == StErr);
    so        = {5'd0, state_q};
    err_code  = err_code_q;
    frame_cnt = frame_cnt_q;
  end

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// tb_frame_seq_ctrl: directed and randomized checks of frame_seq_ctrl against
// a phase-length reference model and reactive write/read stage responders.
module tb_frame_seq_ctrl;

  localparam int unsigned GAP = 2;
  localparam int unsigned TMO = 16;

  logic        clk;
  logic        rst;
  logic        start;
  logic        loop_en;
  logic        abort;
  logic        err_clr;
  logic        fs_wr;
  logic        fd_wr;
  logic        fs_rd;
  logic        fd_rd;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;
  logic [7:0]  so;

  int checks = 0;
  int errors = 0;

  // Responder bookkeeping: cycles seen in fs-high and in release.
  int wi, wj, ri, rj;
  logic [7:0]  so_log  [0:127];
  logic        fsw_log [0:127];
  logic [15:0] exp_cnt;

  frame_seq_ctrl #(
    .GAP_CYC (GAP),
    .TIMEOUT (TMO),
    .TO_W    (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .loop_en   (loop_en),
    .abort     (abort),
    .err_clr   (err_clr),
    .fs_wr     (fs_wr),
    .fd_wr     (fd_wr),
    .fs_rd     (fs_rd),
    .fd_rd     (fd_rd),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .frame_cnt (frame_cnt),
    .so        (so)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a phase that sees its fd change at phase-cycle d takes d+1
  // cycles, unless d reaches TMO-1, in which case ERR follows TMO cycles after
  // the phase began. Frame: WR, WR_REL, GAP, RD, RD_REL, then DONE.
  function automatic void model(input int a, input int b, input int c, input int e,
                                output int d_at, output int e_at, output logic [1:0] code);
    int dl [4];
    int t;
    dl[0] = a; dl[1] = b; dl[2] = c; dl[3] = e;
    t = 1;
    d_at = -1;
    e_at = -1;
    code = 2'd0;
    for (int p = 0; p < 4; p++) begin
      if (dl[p] >= int'(TMO) - 1) begin
        e_at = t + int'(TMO);
        code = (p < 2) ? 2'd1 : 2'd2;
        return;
      end
      t += dl[p] + 1;
      if (p == 1) t += int'(GAP);
    end
    d_at = t;
  endfunction

  // Stage responders: raise fd a cycles into fs, drop it b cycles into release.
  task automatic respond(input int a, input int b, input int c, input int e);
    if (fs_wr) begin
      if (wi >= a) fd_wr = 1'b1;
      wi++;
    end else begin
      wi = 0;
      if (fd_wr) begin
        if (wj >= b) fd_wr = 1'b0;
        wj++;
      end else begin
        wj = 0;
      end
    end
    if (fs_rd) begin
      if (ri >= c) fd_rd = 1'b1;
      ri++;
    end else begin
      ri = 0;
      if (fd_rd) begin
        if (rj >= e) fd_rd = 1'b0;
        rj++;
      end else begin
        rj = 0;
      end
    end
  endtask

  task automatic run_frame(input int a, input int b, input int c, input int e,
                           output int done_at, output int err_at, output logic [1:0] code,
                           output int n_done, output int gap_n);
    done_at = -1;
    err_at  = -1;
    code    = 2'd0;
    n_done  = 0;
    gap_n   = 0;
    wi = 0; wj = 0; ri = 0; rj = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      so_log[k]  = so;
      fsw_log[k] = fs_wr;
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = k;
      end
      if (so == 8'd3) gap_n++;
      if (err && (err_at < 0)) begin
        err_at = k;
        code   = err_code;
      end
      start = (k == 0);
      respond(a, b, c, e);
      if (err_at >= 0) break;
      if ((done_at >= 0) && (k == done_at + 1)) break;
    end
    start = 1'b0;
  endtask

  task automatic clear_err(input string tag);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk({tag, ".clr_state"}, 32'(so), 32'd0);
    chk({tag, ".clr_code"}, 32'(err_code), 32'd0);
  endtask

  task automatic check_frame(input string tag, input int a, input int b, input int c,
                             input int e);
    int m_d, m_e, d_at, e_at, n_done, gap_n;
    logic [1:0] m_code, code;
    model(a, b, c, e, m_d, m_e, m_code);
    run_frame(a, b, c, e, d_at, e_at, code, n_done, gap_n);
    fd_wr = 1'b0;
    fd_rd = 1'b0;
    chk({tag, ".done_at"}, d_at, m_d);
    chk({tag, ".err_at"}, e_at, m_e);
    chk({tag, ".err_code"}, 32'(code), 32'(m_code));
    chk({tag, ".n_done"}, n_done, (m_d >= 0) ? 1 : 0);
    chk({tag, ".gap_cycles"}, gap_n, ((m_e < 0) || (m_code == 2'd2)) ? int'(GAP) : 0);
    if (m_d >= 0) exp_cnt = exp_cnt + 16'd1;
    if (m_e >= 0) clear_err(tag);
    else chk({tag, ".idle_after"}, 32'(so), 32'd0);
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    // Recover from any unexpected state so later steps start from IDLE.
    if (so != 8'd0) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
  endtask

  initial begin
    int m_d, m_e, d_at, e_at, n_done, gap_n, n, idle_n, tenth;
    logic [1:0] m_code, code;
    bit seen;

    rst = 1'b1; start = 1'b0; loop_en = 1'b0; abort = 1'b0; err_clr = 1'b0;
    fd_wr = 1'b0; fd_rd = 1'b0;
    exp_cnt = 16'd0;
    #2 rst = 1'b0;
    #10;
    chk("reset.outputs", 32'({fs_wr, fs_rd, busy, done, err, err_code, frame_cnt, so}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Spurious done flags in IDLE are ignored.
    fd_wr = 1'b1; fd_rd = 1'b1;
    repeat (3) @(negedge clk);
    chk("spurious.so", 32'(so), 32'd0);
    chk("spurious.busy", 32'(busy), 32'd0);
    fd_wr = 1'b0; fd_rd = 1'b0;
    @(negedge clk);

    // Basic frame: fd_wr 5..6, fd_rd 14, gap of two cycles.
    check_frame("basic", 4, 1, 4, 0);
    for (int k = 1; k <= 5; k++) chk($sformatf("basic.fs_wr_c%0d", k), 32'(fsw_log[k]), 32'd1);
    chk("basic.fs_wr_c6", 32'(fsw_log[6]), 32'd0);
    chk("basic.so_c7", 32'(so_log[7]), 32'd2);
    chk("basic.so_c8", 32'(so_log[8]), 32'd3);
    chk("basic.so_c9", 32'(so_log[9]), 32'd3);
    chk("basic.so_c10", 32'(so_log[10]), 32'd4);
    chk("basic.so_c16", 32'(so_log[16]), 32'd6);
    chk("basic.so_c17", 32'(so_log[17]), 32'd0);

    // Loop mode: ten back-to-back frames, then drop loop_en.
    model(3, 0, 3, 0, m_d, m_e, m_code);
    loop_en = 1'b1;
    wi = 0; wj = 0; ri = 0; rj = 0;
    n = 0; idle_n = 0; tenth = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if ((k > 0) && (so == 8'd0)) idle_n++;
      if (done) begin
        n++;
        if (n == 10) tenth = k;
      end
      start = (k == 0);
      respond(3, 0, 3, 0);
      if (n == 10) break;
    end
    start = 1'b0;
    chk("loop.tenth_done", tenth, 10 * m_d);
    chk("loop.idle_visits", idle_n, 0);
    @(negedge clk);
    respond(3, 0, 3, 0);
    exp_cnt = exp_cnt + 16'd10;
    chk("loop.frame_cnt10", 32'(frame_cnt), 32'(exp_cnt));
    chk("loop.rewr", 32'(so), 32'd1);
    loop_en = 1'b0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin
        n++;
        break;
      end
      respond(3, 0, 3, 0);
    end
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    chk("loop.last_done", n, 1);
    chk("loop.end_idle", 32'(so), 32'd0);
    chk("loop.frame_cnt11", 32'(frame_cnt), 32'(exp_cnt));

    // Write timeout: fd_wr never rises.
    model(200, 0, 0, 0, m_d, m_e, m_code);
    run_frame(200, 0, 0, 0, d_at, e_at, code, n_done, gap_n);
    fd_wr = 1'b0; fd_rd = 1'b0;
    chk("wto.err_at", e_at, m_e);
    chk("wto.err_at_abs", e_at, 17);
    chk("wto.code", 32'(code), 32'd1);
    chk("wto.fs_wr", 32'(fs_wr), 32'd0);
    chk("wto.err", 32'(err), 32'd1);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wto.hold_so", 32'(so), 32'd7);
      chk("wto.hold_code", 32'(err_code), 32'd1);
    end
    start = 1'b0;
    clear_err("wto");

    // Timeout coincident with fd edge: timeout wins (write and read).
    check_frame("wto_coinc", 15, 0, 0, 0);
    check_frame("rto_coinc", 0, 0, 15, 0);

    // Abort plus err_clr together in ERR.
    run_frame(200, 0, 0, 0, d_at, e_at, code, n_done, gap_n);
    fd_wr = 1'b0; fd_rd = 1'b0;
    abort = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    abort = 1'b0; err_clr = 1'b0;
    chk("abclr.so", 32'(so), 32'd0);
    chk("abclr.code", 32'(err_code), 32'd0);

    // Abort while fs_rd is high.
    seen = 1'b0;
    wi = 0; wj = 0; ri = 0; rj = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      start = (k == 0);
      respond(1, 0, 100, 0);
      if (fs_rd) begin
        seen = 1'b1;
        abort = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("abort.reached_rd", 32'(seen), 32'd1);
    @(negedge clk);
    abort = 1'b0;
    chk("abort.so", 32'(so), 32'd0);
    chk("abort.fs_rd", 32'(fs_rd), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("abort.no_done", n, 0);

    // Stuck-high fd_wr at frame entry: fs_wr pulses for one cycle.
    fd_wr = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("stuck.so_wr", 32'(so), 32'd1);
    chk("stuck.fs_wr_hi", 32'(fs_wr), 32'd1);
    @(negedge clk);
    chk("stuck.so_wrrel", 32'(so), 32'd2);
    chk("stuck.fs_wr_lo", 32'(fs_wr), 32'd0);
    fd_wr = 1'b0;
    wi = 0; wj = 0; ri = 0; rj = 0;
    n = 0; d_at = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        n++;
        d_at = 3 + k;
        break;
      end
      respond(0, 0, 1, 0);
    end
    // WR_REL leaves at cycle 2, gap, RD for 2 cycles, RD_REL 1, then DONE.
    chk("stuck.done_at", d_at, 3 + int'(GAP) + 2 + 1);
    chk("stuck.n_done", n, 1);
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    chk("stuck.frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

    // Randomized frames against the model.
    for (int i = 0; i < 12; i++) begin
      check_frame($sformatf("rnd%0d", i), int'($urandom_range(0, 16)),
                  int'($urandom_range(0, 16)), int'($urandom_range(0, 16)),
                  int'($urandom_range(0, 16)));
    end

    // Asynchronous reset in the middle of GAP.
    seen = 1'b0;
    wi = 0; wj = 0; ri = 0; rj = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      start = (k == 0);
      respond(0, 0, 0, 0);
      if (so == 8'd3) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("rst.reached_gap", 32'(seen), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst.async_outputs", 32'({fs_wr, fs_rd, busy, done, err, err_code, frame_cnt, so}),
        32'd0);
    @(negedge clk);
    rst = 1'b1;
    fd_wr = 1'b0; fd_rd = 1'b0;
    exp_cnt = 16'd0;
    @(negedge clk);
    chk("rst.idle_after", 32'(so), 32'd0);

    // Frame counter wrap from 0xFFFF.
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    chk("wrap.hold", 32'(frame_cnt), 32'h0000FFFF);
    exp_cnt = 16'hFFFF;
    check_frame("wrap", 1, 0, 1, 0);
    chk("wrap.zero", 32'(frame_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_seq_ctrl.md
Name: frame_seq_ctrl

Overview:
- Sequencer for the receive test path: RAM-write stage (ramw → fifoe) first, then MAC-read stage (fifoe → mac2fifoc), once per frame.
- Drives each stage's fs (flag start) and checks its fd (flag done) using a four-phase handshake.
- Adds a programmable inter-stage gap, per-stage timeout, abort, continuous-loop mode, a frame counter and a state export for debug.

Parameters:
- GAP_CYC, 2, idle cycles between write-stage release and read-stage start (0 = no gap).
- TIMEOUT, 4096, max cycles per handshake phase before error (0 = timeout disabled).
- TO_W, 16, timeout/gap counter width; must satisfy TIMEOUT < 2^TO_W and GAP_CYC < 2^TO_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- start  in  1  begin one frame; sampled only in IDLE.
- loop_en  in  1  when 1, DONE returns directly to WR (free-running).
- abort  in  1  synchronous abort to IDLE from any state.
- err_clr  in  1  leave ERR and return to IDLE.
- fs_wr  out  1  start flag to write stage.
- fd_wr  in  1  done flag from write stage.
- fs_rd  out  1  start flag to read stage.
- fd_rd  in  1  done flag from read stage.
- busy  out  1  high in any state except IDLE and ERR.
- done  out  1  one-cycle pulse per completed frame.
- err  out  1  high while in ERR.
- err_code  out  2  0 none, 1 write timeout, 2 read timeout; holds its value until err_clr.
- frame_cnt  out  16  completed frames; wraps from 0xFFFF to 0x0000.
- so  out  8  current state code, zero-extended.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, counters 0, frame_cnt 0, err_code 0.
  - All outputs are 0 during reset.
- fs_wr, fs_rd, busy, done, err and so are decoded from the registered state only; no input-to-output combinational path.
- State codes: IDLE 0, WR 1, WR_REL 2, GAP 3, RD 4, RD_REL 5, DONE 6, ERR 7.
- IDLE:
  - start=1 → WR on the next edge; fs_wr goes high one cycle after start is sampled.
- WR: fs_wr=1.
  - fd_wr=1 → WR_REL.
- WR_REL: fs_wr=0.
  - fd_wr=0 → GAP if GAP_CYC>0, else → RD.
  - fd_wr already low on the first WR_REL cycle → leaves after 1 cycle.
- GAP: counts GAP_CYC cycles, then → RD.
  - Exactly GAP_CYC cycles are spent in GAP.
- RD: fs_rd=1.
  - fd_rd=1 → RD_REL.
- RD_REL: fs_rd=0.
  - fd_rd=0 → DONE.
- DONE: exactly one cycle.
  - done=1 and frame_cnt increments on the exit edge.
  - Next state: WR if loop_en=1, else IDLE. start is ignored in DONE.
- Timeout counter:
  - Cleared on every state change.
  - Increments each cycle in WR, WR_REL, RD and RD_REL.
  - If TIMEOUT>0 and count reaches TIMEOUT-1 without the exit condition → ERR.
  - err_code = 1 from WR/WR_REL, 2 from RD/RD_REL.
- ERR: err=1; fs_wr=fs_rd=0.
  - Stays in ERR regardless of start or loop_en.
  - err_clr=1 → IDLE and err_code → 0.
- abort=1 in any state other than IDLE → IDLE on the next edge.
  - No done pulse, frame_cnt unchanged.
  - From ERR, abort also clears err_code.
- Priority when inputs coincide: abort > err_clr > timeout > fd/start transition.
- Spurious fd:
  - fd_wr/fd_rd high in IDLE, GAP or DONE is ignored.
  - fd_rd high during WR is ignored.
- Stuck-high fd: if fd_wr is still high when the next frame enters WR, the controller passes straight to WR_REL. This is legal; the bench must check that fs_wr pulses for one cycle.
- Expected size: roughly 150–200 lines of RTL (FSM, two counters, output decode).

Test Plan:
- Basic frame, GAP_CYC=2, loop_en=0:
  - Stimulus: start pulse at cycle 0; fd_wr high at cycle 5, low at 7; fd_rd high at 14, low at 15.
  - Required: fs_wr high cycles 1–5; GAP for exactly 2 cycles; fs_rd asserted afterwards; done pulses once; frame_cnt=1; returns to IDLE (so=0).
- Loop mode:
  - Stimulus: loop_en=1; responders acknowledge 3 cycles after each fs.
  - Required: back-to-back frames with no IDLE visit; after 10 done pulses frame_cnt=10.
  - Then drop loop_en: the controller ends in IDLE after the current frame.
- Write timeout, TIMEOUT=16:
  - Stimulus: start; fd_wr never asserts.
  - Required: ERR (so=7) 16 cycles after entering WR; err=1, err_code=1, fs_wr=0; start ignored.
  - err_clr → IDLE with err_code=0.
- Abort in RD:
  - Stimulus: assert abort while fs_rd=1.
  - Required: IDLE next cycle; fs_rd=0; no done pulse; frame_cnt unchanged.
- Reset mid-frame and wrap:
  - Stimulus: rst low during GAP.
  - Required: all outputs 0 immediately (asynchronously).
  - Wrap: preload frame_cnt=0xFFFF via 65535 fast frames (or a force in the bench); the next frame gives 0x0000.
- Coincident events:
  - Stimulus: abort and err_clr together in ERR → IDLE with err_code=0.
  - Stimulus: fd_wr rising on the same cycle the timeout expires → ERR (timeout wins).
